// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures commit/exception records into a FWFT FIFO with all-or-nothing admission.
// Optional macro COMMIT_TRACE_DEBUG_FILTER_EN suppresses records formed while in debug mode.
module commit_trace_buffer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned DROP_CNT_W      = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   enable_i,
    input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0][63:0]       commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0][31:0]       commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]             we_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]        waddr_i,
    input  logic [NR_COMMIT_PORTS-1:0][63:0]       wdata_i,
    input  logic [1:0]                             priv_lvl_i,
    input  logic                                   debug_mode_i,
    input  logic                                   ex_valid_i,
    input  logic [63:0]                            ex_pc_i,
    input  logic [63:0]                            ex_cause_i,
    output logic                                   trace_valid_o,
    input  logic                                   trace_ready_i,
    output logic                                   trace_kind_o,
    output logic [63:0]                            trace_pc_o,
    output logic [31:0]                            trace_instr_o,
    output logic [4:0]                             trace_rd_o,
    output logic                                   trace_we_o,
    output logic [63:0]                            trace_data_o,
    output logic [1:0]                             trace_priv_o,
    output logic [63:0]                            trace_cycle_o,
    output logic                                   trace_lost_o,
    output logic [$clog2(DEPTH):0]                 level_o,
    output logic [DROP_CNT_W-1:0]                  drop_cnt_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

`ifdef COMMIT_TRACE_DEBUG_FILTER_EN
    localparam bit DBG_FILTER = 1'b1;
`else
    localparam bit DBG_FILTER = 1'b0;
`endif

    typedef struct packed {
        logic        kind;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] data;
        logic [1:0]  priv;
        logic [63:0] cycle;
        logic        lost;
    } rec_t;

    rec_t                  r_mem [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [LW-1:0]         r_level;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [63:0]           r_cycle;
    logic                  r_lost_pend;

    logic                  w_capture;
    logic [LW-1:0]         w_off [NR_COMMIT_PORTS];
    logic [LW-1:0]         w_n_ins;
    logic [LW-1:0]         w_n_rec;
    logic [LW-1:0]         w_space;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [DROP_CNT_W:0]   w_drop_sum;
    rec_t                  w_rec [NR_COMMIT_PORTS+1];
    rec_t                  w_head;

    // Slot offsets in port order, record count and admission decision against start-of-cycle level.
    always_comb begin
        w_capture = enable_i && !(DBG_FILTER && debug_mode_i);
        w_n_ins   = '0;
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            w_off[p] = w_n_ins;
            if (commit_ack_i[p]) begin
                w_n_ins = w_n_ins + LW'(1);
            end
        end
        w_n_rec    = w_capture ? (w_n_ins + LW'(ex_valid_i)) : '0;
        w_space    = LW'(DEPTH) - r_level;
        w_push     = (w_n_rec != '0) && (w_n_rec <= w_space);
        w_drop     = (w_n_rec != '0) && (w_n_rec > w_space);
        w_pop      = (r_level != '0) && trace_ready_i;
        w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_n_rec);
    end

    // Record payloads; only the first record of an admitted batch carries the lost marker.
    always_comb begin
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            w_rec[p].kind  = 1'b0;
            w_rec[p].pc    = commit_pc_i[p];
            w_rec[p].instr = commit_instr_i[p];
            w_rec[p].rd    = waddr_i[p];
            w_rec[p].we    = we_i[p];
            w_rec[p].data  = wdata_i[p];
            w_rec[p].priv  = priv_lvl_i;
            w_rec[p].cycle = r_cycle;
            w_rec[p].lost  = r_lost_pend && (w_off[p] == '0);
        end
        w_rec[NR_COMMIT_PORTS].kind  = 1'b1;
        w_rec[NR_COMMIT_PORTS].pc    = ex_pc_i;
        w_rec[NR_COMMIT_PORTS].instr = '0;
        w_rec[NR_COMMIT_PORTS].rd    = '0;
        w_rec[NR_COMMIT_PORTS].we    = 1'b0;
        w_rec[NR_COMMIT_PORTS].data  = ex_cause_i;
        w_rec[NR_COMMIT_PORTS].priv  = priv_lvl_i;
        w_rec[NR_COMMIT_PORTS].cycle = r_cycle;
        w_rec[NR_COMMIT_PORTS].lost  = r_lost_pend && (w_n_ins == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
                if (commit_ack_i[p]) begin
                    r_mem[r_wr_ptr + PW'(w_off[p])] <= w_rec[p];
                end
            end
            if (ex_valid_i) begin
                r_mem[r_wr_ptr + PW'(w_n_ins)] <= w_rec[NR_COMMIT_PORTS];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_drop_cnt  <= '0;
            r_cycle     <= '0;
            r_lost_pend <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            r_level <= r_level + (w_push ? w_n_rec : '0) - LW'(w_pop);
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PW'(w_n_rec);
                r_lost_pend <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_drop) begin
                r_lost_pend <= 1'b1;
                r_drop_cnt  <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign trace_valid_o = (r_level != '0);
    assign trace_kind_o  = w_head.kind;
    assign trace_pc_o    = w_head.pc;
    assign trace_instr_o = w_head.instr;
    assign trace_rd_o    = w_head.rd;
    assign trace_we_o    = w_head.we;
    assign trace_data_o  = w_head.data;
    assign trace_priv_o  = w_head.priv;
    assign trace_cycle_o = w_head.cycle;
    assign trace_lost_o  = w_head.lost;
    assign level_o       = r_level;
    assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed testbench for commit_trace_buffer (NR_COMMIT_PORTS=2, DEPTH=16).
module tb_commit_trace_buffer;
    localparam int unsigned NR = 2;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               enable_i;
    logic [NR-1:0]      commit_ack_i;
    logic [NR-1:0][63:0] commit_pc_i;
    logic [NR-1:0][31:0] commit_instr_i;
    logic [NR-1:0]      we_i;
    logic [NR-1:0][4:0] waddr_i;
    logic [NR-1:0][63:0] wdata_i;
    logic [1:0]         priv_lvl_i;
    logic               debug_mode_i;
    logic               ex_valid_i;
    logic [63:0]        ex_pc_i;
    logic [63:0]        ex_cause_i;
    logic               trace_valid_o;
    logic               trace_ready_i;
    logic               trace_kind_o;
    logic [63:0]        trace_pc_o;
    logic [31:0]        trace_instr_o;
    logic [4:0]         trace_rd_o;
    logic               trace_we_o;
    logic [63:0]        trace_data_o;
    logic [1:0]         trace_priv_o;
    logic [63:0]        trace_cycle_o;
    logic               trace_lost_o;
    logic [4:0]         level_o;
    logic [31:0]        drop_cnt_o;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] cyc    = '0;

    commit_trace_buffer #(.NR_COMMIT_PORTS(NR), .DEPTH(16), .DROP_CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .commit_ack_i(commit_ack_i),
        .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i), .we_i(we_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .priv_lvl_i(priv_lvl_i),
        .debug_mode_i(debug_mode_i), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
        .ex_cause_i(ex_cause_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_kind_o(trace_kind_o), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
        .trace_rd_o(trace_rd_o), .trace_we_o(trace_we_o), .trace_data_o(trace_data_o),
        .trace_priv_o(trace_priv_o), .trace_cycle_o(trace_cycle_o), .trace_lost_o(trace_lost_o),
        .level_o(level_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs and outputs are handled 1 time unit after the edge.
    task automatic tick();
        logic was_rst;
        was_rst = rst_i;
        @(posedge clk_i);
        #1;
        cyc = was_rst ? 64'd0 : cyc + 64'd1;
    endtask

    task automatic set_commit(input logic [1:0] ack, input logic [63:0] pc0, input logic [63:0] pc1);
        commit_ack_i      = ack;
        commit_pc_i[0]    = pc0;
        commit_pc_i[1]    = pc1;
        commit_instr_i[0] = pc0[31:0] ^ 32'h13;
        commit_instr_i[1] = pc1[31:0] ^ 32'h13;
        we_i              = 2'b11;
        waddr_i[0]        = 5'd1;
        waddr_i[1]        = 5'd2;
        wdata_i[0]        = pc0 + 64'h10;
        wdata_i[1]        = pc1 + 64'h10;
    endtask

    task automatic drain(input int n);
        trace_ready_i = 1'b1;
        repeat (n) tick();
        trace_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b1; debug_mode_i = 1'b0; ex_valid_i = 1'b0;
        ex_pc_i = '0; ex_cause_i = '0; priv_lvl_i = 2'd3; trace_ready_i = 1'b0;
        set_commit(2'b00, 64'h0, 64'h0);
        tick(); tick();
        rst_i = 1'b0;
        checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", trace_valid_o); end
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        checks++; if (drop_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
    endtask

    task automatic test_two_commits();
        logic [63:0] stamp;
        trace_ready_i = 1'b1;
        stamp = cyc;
        set_commit(2'b11, 64'h8000_0000, 64'h8000_0004);
        tick();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++; if (trace_pc_o !== 64'h8000_0000) begin errors++; $display("FAIL two_pc0 got=%h exp=80000000", trace_pc_o); end
        checks++; if (trace_cycle_o !== stamp) begin errors++; $display("FAIL two_cyc0 got=%0d exp=%0d", trace_cycle_o, stamp); end
        checks++; if ({trace_kind_o, trace_rd_o, trace_we_o, trace_data_o} !== {1'b0, 5'd1, 1'b1, 64'h8000_0010}) begin
            errors++; $display("FAIL two_fields0 got=%0b/%0d/%0b/%h exp=0/1/1/80000010", trace_kind_o, trace_rd_o, trace_we_o, trace_data_o); end
        tick();
        checks++; if (trace_pc_o !== 64'h8000_0004) begin errors++; $display("FAIL two_pc1 got=%h exp=80000004", trace_pc_o); end
        checks++; if (trace_cycle_o !== stamp) begin errors++; $display("FAIL two_cyc1 got=%0d exp=%0d", trace_cycle_o, stamp); end
        checks++; if (trace_instr_o !== 32'h8000_0017) begin errors++; $display("FAIL two_instr1 got=%h exp=80000017", trace_instr_o); end
        tick();
        checks++; if (level_o !== 5'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL two_empty level=%0d valid=%0b exp=0/0", level_o, trace_valid_o); end
        trace_ready_i = 1'b0;
    endtask

    task automatic test_exception();
        set_commit(2'b01, 64'h2000, 64'h0);
        ex_valid_i = 1'b1; ex_pc_i = 64'h3000; ex_cause_i = 64'h2;
        tick();
        set_commit(2'b00, 64'h0, 64'h0); ex_valid_i = 1'b0;
        checks++; if (level_o !== 5'd2) begin errors++; $display("FAIL exc_level got=%0d exp=2", level_o); end
        checks++; if (trace_kind_o !== 1'b0 || trace_pc_o !== 64'h2000) begin errors++; $display("FAIL exc_first kind=%0b pc=%h exp=0/2000", trace_kind_o, trace_pc_o); end
        trace_ready_i = 1'b1;
        tick();
        checks++; if ({trace_kind_o, trace_pc_o, trace_data_o} !== {1'b1, 64'h3000, 64'h2}) begin
            errors++; $display("FAIL exc_rec kind=%0b pc=%h data=%h exp=1/3000/2", trace_kind_o, trace_pc_o, trace_data_o); end
        checks++; if ({trace_instr_o, trace_rd_o, trace_we_o} !== 38'd0) begin
            errors++; $display("FAIL exc_zero instr=%h rd=%0d we=%0b exp=0/0/0", trace_instr_o, trace_rd_o, trace_we_o); end
        tick();
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL exc_drain got=%0d exp=0", level_o); end
        trace_ready_i = 1'b0;
    endtask

    task automatic test_drop_lost();
        for (int i = 0; i < 7; i++) begin
            set_commit(2'b11, 64'h100 + 64'(i * 8), 64'h104 + 64'(i * 8));
            tick();
        end
        set_commit(2'b01, 64'h200, 64'h0);
        tick();
        checks++; if (level_o !== 5'd15) begin errors++; $display("FAIL fill_level got=%0d exp=15", level_o); end
        set_commit(2'b11, 64'h400, 64'h404);
        tick();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++; if (level_o !== 5'd15) begin errors++; $display("FAIL drop_level got=%0d exp=15", level_o); end
        checks++; if (drop_cnt_o !== 32'd2) begin errors++; $display("FAIL drop_cnt got=%0d exp=2", drop_cnt_o); end
        checks++; if (trace_pc_o !== 64'h100 || trace_lost_o !== 1'b0) begin errors++; $display("FAIL hold_head pc=%h lost=%0b exp=100/0", trace_pc_o, trace_lost_o); end
        drain(15);
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL drop_drain got=%0d exp=0", level_o); end
        set_commit(2'b01, 64'h300, 64'h0);
        tick();
        checks++; if (trace_lost_o !== 1'b1 || trace_pc_o !== 64'h300) begin errors++; $display("FAIL lost_set lost=%0b pc=%h exp=1/300", trace_lost_o, trace_pc_o); end
        trace_ready_i = 1'b1;
        set_commit(2'b01, 64'h304, 64'h0);
        tick();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++; if (trace_lost_o !== 1'b0 || trace_pc_o !== 64'h304 || level_o !== 5'd1) begin
            errors++; $display("FAIL lost_clear lost=%0b pc=%h level=%0d exp=0/304/1", trace_lost_o, trace_pc_o, level_o); end
        tick();
        trace_ready_i = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) begin
            set_commit(2'b11, 64'h600 + 64'(i * 8), 64'h604 + 64'(i * 8));
            tick();
        end
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_level got=%0d exp=16", level_o); end
        trace_ready_i = 1'b1;
        set_commit(2'b01, 64'h700, 64'h0);
        tick();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++; if (level_o !== 5'd15 || drop_cnt_o !== 32'd3) begin
            errors++; $display("FAIL full_pop level=%0d drop=%0d exp=15/3", level_o, drop_cnt_o); end
        drain(15);
    endtask

    task automatic test_enable_debug();
        enable_i = 1'b0;
        set_commit(2'b11, 64'h800, 64'h804);
        tick();
        checks++; if (level_o !== 5'd0 || drop_cnt_o !== 32'd3) begin
            errors++; $display("FAIL disabled level=%0d drop=%0d exp=0/3", level_o, drop_cnt_o); end
        enable_i = 1'b1; debug_mode_i = 1'b1;
        tick();
        debug_mode_i = 1'b0;
        set_commit(2'b00, 64'h0, 64'h0);
`ifdef COMMIT_TRACE_DEBUG_FILTER_EN
        checks++; if (level_o !== 5'd0 || drop_cnt_o !== 32'd3) begin
            errors++; $display("FAIL debug_filter level=%0d drop=%0d exp=0/3", level_o, drop_cnt_o); end
`else
        checks++; if (level_o !== 5'd2 || trace_pc_o !== 64'h800 || drop_cnt_o !== 32'd3) begin
            errors++; $display("FAIL debug_capture level=%0d pc=%h drop=%0d exp=2/800/3", level_o, trace_pc_o, drop_cnt_o); end
`endif
        drain(2);
    endtask

    task automatic test_reset_mid();
        set_commit(2'b11, 64'h900, 64'h904); tick();
        set_commit(2'b11, 64'h908, 64'h90c); tick();
        set_commit(2'b01, 64'h910, 64'h0);   tick();
        checks++; if (level_o !== 5'd5) begin errors++; $display("FAIL pre_rst_level got=%0d exp=5", level_o); end
        rst_i = 1'b1;
        set_commit(2'b11, 64'ha00, 64'ha04);
        tick();
        rst_i = 1'b0;
        checks++; if (trace_valid_o !== 1'b0 || level_o !== 5'd0 || drop_cnt_o !== 32'd0) begin
            errors++; $display("FAIL mid_rst valid=%0b level=%0d drop=%0d exp=0/0/0", trace_valid_o, level_o, drop_cnt_o); end
        set_commit(2'b01, 64'hb00, 64'h0);
        tick();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++; if (trace_cycle_o !== 64'd0 || trace_pc_o !== 64'hb00 || level_o !== 5'd1) begin
            errors++; $display("FAIL rst_stamp cyc=%0d pc=%h level=%0d exp=0/b00/1", trace_cycle_o, trace_pc_o, level_o); end
        checks++; if (cyc !== 64'd1) begin errors++; $display("FAIL bench_cycle got=%0d exp=1", cyc); end
    endtask

    initial begin
        test_reset();
        test_two_commits();
        test_exception();
        test_drop_lost();
        test_full_pop();
        test_enable_debug();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of commit ports sampled per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, trace record entries (power of two, >= NR_COMMIT_PORTS+1).
REQ-003 SHALL have parameter DROP_CNT_W, default 32, width of the saturating drop counter.
REQ-004 SHALL have ports (name  direction  width  meaning):
 clk_i  in  1  single clock, rising edge; reset is synchronous and active-high
 rst_i  in  1  synchronous active-high reset
 enable_i  in  1  capture enable
 commit_ack_i  in  NR_COMMIT_PORTS  per-port commit strobe
 commit_pc_i  in  NR_COMMIT_PORTS x 64  committed PC
 commit_instr_i  in  NR_COMMIT_PORTS x 32  committed instruction word
 we_i  in  NR_COMMIT_PORTS  register write valid
 waddr_i  in  NR_COMMIT_PORTS x 5  destination register
 wdata_i  in  NR_COMMIT_PORTS x 64  write-back data
 priv_lvl_i  in  2  current privilege level
 debug_mode_i  in  1  core in debug mode
 ex_valid_i  in  1  exception taken this cycle
 ex_pc_i  in  64  faulting PC
 ex_cause_i  in  64  exception cause
 trace_valid_o  out  1  record available
 trace_ready_i  in  1  consumer accepts record
 trace_kind_o  out  1  0 = instruction, 1 = exception
 trace_pc_o  out  64  record PC
 trace_instr_o  out  32  instruction word (0 for exceptions)
 trace_rd_o  out  5  destination (0 for exceptions)
 trace_we_o  out  1  write-back valid
 trace_data_o  out  64  wdata, or cause for exceptions
 trace_priv_o  out  2  privilege at capture
 trace_cycle_o  out  64  cycle stamp at capture
 trace_lost_o  out  1  records dropped immediately before this one
 level_o  out  clog2(DEPTH)+1  occupied entries
 drop_cnt_o  out  DROP_CNT_W  total dropped records

Function
REQ-005 SHALL keep a free-running 64-bit cycle counter, +1 every cycle out of reset, wrapping to 0 after all-ones.
REQ-006 SHALL form, per cycle with enable_i=1, one instruction record per asserted commit_ack_i plus one exception record if ex_valid_i=1.
REQ-007 SHALL write records in order port 0 .. NR_COMMIT_PORTS-1, exception last, in consecutive FIFO slots, all stamped with the same cycle value.
REQ-008 SHALL admit a cycle's records only if all fit in (DEPTH - level at cycle start); otherwise drop all of them (all-or-nothing).
REQ-009 SHALL on drop add the dropped record count to drop_cnt_o, saturating at all-ones, and set a pending-lost flag.
REQ-010 SHALL set trace_lost_o=1 on the first record written after any drop, then clear the pending-lost flag.
REQ-011 SHALL be first-word-fall-through: trace_valid_o = (level > 0); pop on trace_valid_o && trace_ready_i.
REQ-012 SHALL update level as level + pushed - popped in one cycle; a pop in the same cycle does not increase admission space (REQ-008 uses start-of-cycle level).
REQ-013 SHALL use wrapping read/write pointers modulo DEPTH; full = level==DEPTH, empty = level==0.
REQ-014 SHALL hold output fields stable while trace_valid_o=1 and trace_ready_i=0.
REQ-015 SHALL with enable_i=0 capture nothing and count no drops; buffered records still drain.

Reset
REQ-016 SHALL on rst_i=1 at a clock edge clear pointers, level_o, drop_cnt_o, cycle counter, pending-lost flag; trace_valid_o=0 in the following cycle.
REQ-017 SHALL discard inputs presented in a reset cycle; reset mid-drain discards buffered records.

Configuration
REQ-018 SHALL honour macro COMMIT_TRACE_DEBUG_FILTER_EN: defined -> records formed while debug_mode_i=1 are suppressed (not written, not counted as drops); undefined -> debug-mode records captured normally.

Verification
REQ-019 Port0+port1 commit, pc 0x80000000/0x80000004, ready=1 -> two records in port order, same trace_cycle_o, level returns to 0.
REQ-020 ready=0, fill to DEPTH-1 (DEPTH=16), then 2 commits -> both dropped, drop_cnt_o=2, level 15; after drain, next record has trace_lost_o=1.
REQ-021 Commit on port0 plus ex_valid_i cause 0x2 -> instruction record then exception record with trace_data_o=0x2, kind=1.
REQ-022 Full buffer, ready=1, one commit same cycle -> commit dropped (REQ-012), level 15 afterwards.
REQ-023 debug_mode_i=1 with commits -> with COMMIT_TRACE_DEBUG_FILTER_EN no records, drop_cnt_o unchanged; without it records captured.
REQ-024 Assert rst_i with 5 buffered records -> next cycle trace_valid_o=0, level_o=0, drop_cnt_o=0, cycle stamp restarts at 0.
